// File: rtl/pipe_pkg.sv
// Shared constants for the five-stage pipeline registers: control-bundle bit
// positions, per-stage bundle widths and the bubble encoding.
package pipe_pkg;

    // Default widths of the generic stage register
    localparam int CTRL_W_DEF = 16;
    localparam int DATA_W_DEF = 104;
    localparam int CNT_W_DEF  = 16;

    // Control-bundle bit positions
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_BRANCH     = 4;
    localparam int CTRL_JUMP       = 5;
    localparam int CTRL_ALU_SRC    = 6;
    localparam int CTRL_SP_WRITE   = 7;
    localparam int CTRL_ALU_OP_LSB = 8;
    localparam int CTRL_ALU_OP_W   = 4;
    localparam int CTRL_IRQ_ACK    = 12;

    // Per-stage bundle widths; the payload carries register numbers,
    // operand values, address and SP as each stage needs them
    localparam int IF_ID_CTRL_W  = 16;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_CTRL_W  = 16;
    localparam int ID_EX_DATA_W  = 104;
    localparam int EX_MEM_CTRL_W = 16;
    localparam int EX_MEM_DATA_W = 72;
    localparam int MEM_WB_CTRL_W = 16;
    localparam int MEM_WB_DATA_W = 40;

    // A bubble drives every control bit to this value, so it never writes
    localparam logic CTRL_BUBBLE = 1'b0;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid holding register with a valid flag; only instantiated by
// pipe_stage_reg when PIPE_STAGE_SKID_EN is defined.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [CTRL_W-1:0] push_ctrl,
    input  logic [DATA_W-1:0] push_data,
    output logic              skid_valid,
    output logic [CTRL_W-1:0] skid_ctrl,
    output logic [DATA_W-1:0] skid_data
);

    logic              vld_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [DATA_W-1:0] data_p1;

    // ---- skid stage register ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= '0;
            data_p1 <= '0;
        end else if (clear || pop) begin
            vld_p1  <= 1'b0;
        end else if (push) begin
            vld_p1  <= 1'b1;
            ctrl_p1 <= push_ctrl;
            data_p1 <= push_data;
        end
    end

    assign skid_valid = vld_p1;
    assign skid_ctrl  = ctrl_p1;
    assign skid_data  = data_p1;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall, flush, ready/valid and a
// saturating stall counter. Define PIPE_STAGE_SKID_EN for a 1-entry skid buffer.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cycles
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic              vld_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [DATA_W-1:0] data_p1;
    logic [CNT_W-1:0]  cnt_p1;

    logic              accept;
    logic              drain;
    logic              load_main;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;

    assign accept = in_valid & in_ready;
    // A stalled stage is never considered drained, even if out_ready is high
    assign drain  = vld_p1 & out_ready & ~stall;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              skid_push;
    logic              skid_pop;

    assign in_ready  = reset & ~stall & ~flush & ~skid_valid;
    assign skid_push = accept & vld_p1 & ~drain;
    assign skid_pop  = skid_valid & ~stall & ~flush & (drain | ~vld_p1);
    assign load_main = skid_pop | (accept & (~vld_p1 | drain));
    // The skid entry is older than anything upstream, so it always goes first
    assign main_ctrl = skid_valid ? skid_ctrl : in_ctrl;
    assign main_data = skid_valid ? skid_data : in_data;

    pipe_skid_buf #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush),
        .push       (skid_push),
        .pop        (skid_pop),
        .push_ctrl  (in_ctrl),
        .push_data  (in_data),
        .skid_valid (skid_valid),
        .skid_ctrl  (skid_ctrl),
        .skid_data  (skid_data)
    );
`else
    assign in_ready  = reset & ~stall & ~flush & (~vld_p1 | out_ready);
    assign load_main = accept;
    assign main_ctrl = in_ctrl;
    assign main_data = in_data;
`endif

    // ---- main stage register ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= '0;
            data_p1 <= '0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= {CTRL_W{CTRL_BUBBLE}};
        end else if (load_main) begin
            vld_p1  <= 1'b1;
            ctrl_p1 <= main_ctrl;
            data_p1 <= main_data;
        end else if (drain) begin
            vld_p1  <= 1'b0;
        end
    end

    // ---- stall / back-pressure counter ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_p1 <= '0;
        end else if (stall || (vld_p1 && !out_ready)) begin
            cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign out_valid    = vld_p1;
    assign out_ctrl     = vld_p1 ? ctrl_p1 : {CTRL_W{CTRL_BUBBLE}};
    assign out_data     = data_p1;
    assign stall_cycles = cnt_p1;

endmodule
